// File: rtl/pipe_adder_pkg.sv
// Shared types and defaults for the pipelined adder.
// Latency: n/a (types only).
// Backpressure: n/a.
package pipe_adder_pkg;

    localparam int DEF_WIDTH  = 32;
    localparam int DEF_STAGES = 4;

    // Status flags carried alongside a result when the flag option is built in.
    typedef struct packed {
        logic ovf;   // signed overflow of the effective operands
        logic zero;  // sum == 0
        logic neg;   // sum msb
    } flags_t;

    // One complete result beat at the default width.
    typedef struct packed {
        logic [DEF_WIDTH-1:0] sum;
        logic                 cout;
        flags_t               flags;
    } result_t;

    // The operand must split evenly into one chunk per stage.
    function automatic logic chunk_ok(int width, int stages);
        return (stages > 0) && (width > 0) && ((width % stages) == 0);
    endfunction

endpackage

// File: rtl/pipe_adder_if.sv
// Operand/result bus of the pipelined adder (valid/ready on both sides).
// Latency: n/a (wiring only).
// Backpressure: out_ready from the consumer, in_ready back to the producer.
// Flag outputs exist only when PIPE_ADDER_FLAGS_EN is defined.
interface pipe_adder_if
    import pipe_adder_pkg::*;
#(
    parameter int WIDTH = DEF_WIDTH
);
    logic             in_valid;
    logic             in_ready;
    logic [WIDTH-1:0] a;
    logic [WIDTH-1:0] b;
    logic             cin;
    logic             sub;
    logic             out_valid;
    logic             out_ready;
    logic [WIDTH-1:0] sum;
    logic             cout;
`ifdef PIPE_ADDER_FLAGS_EN
    logic             ovf;
    logic             zero;
    logic             neg;

    modport master (
        output in_valid, a, b, cin, sub, out_ready,
        input  in_ready, out_valid, sum, cout, ovf, zero, neg
    );
    modport slave (
        input  in_valid, a, b, cin, sub, out_ready,
        output in_ready, out_valid, sum, cout, ovf, zero, neg
    );
`else
    modport master (
        output in_valid, a, b, cin, sub, out_ready,
        input  in_ready, out_valid, sum, cout
    );
    modport slave (
        input  in_valid, a, b, cin, sub, out_ready,
        output in_ready, out_valid, sum, cout
    );
`endif
endinterface

// File: rtl/pipe_adder_add_chunk.sv
// C-bit combinational ripple-carry adder used as one pipeline stage slice.
// Latency: 0 cycles (purely combinational).
// Backpressure: none; the enclosing stage register decides when to capture.
module add_chunk
    import pipe_adder_pkg::*;
#(
    parameter int C = DEF_WIDTH / DEF_STAGES
) (
    input  logic [C-1:0] a,
    input  logic [C-1:0] b,
    input  logic         ci,
    output logic [C-1:0] s,
    output logic         co
);

    // Bit-serial ripple: each bit's carry feeds the next.
    always_comb begin : ripple
        logic c;
        c = ci;
        s = '0;
        for (int i = 0; i < C; i++) begin
            s[i] = a[i] ^ b[i] ^ c;
            c    = (a[i] & b[i]) | (c & (a[i] ^ b[i]));
        end
        co = c;
    end

endmodule

// File: rtl/pipe_adder.sv
// Pipelined adder/subtractor: one WIDTH/STAGES-bit chunk added per stage, skewed operands.
// Latency: STAGES cycles from input handshake to out_valid; one beat per cycle sustained.
// Backpressure: whole pipe stalls when the output beat is not taken; in_ready = !out_valid || out_ready.
// Optional flag outputs (ovf/zero/neg) built when PIPE_ADDER_FLAGS_EN is defined.
module pipe_adder
    import pipe_adder_pkg::*;
#(
    parameter int WIDTH  = DEF_WIDTH,
    parameter int STAGES = DEF_STAGES
) (
    input  logic        clk,
    input  logic        rst,
    pipe_adder_if.slave bus
);

    localparam int C = WIDTH / STAGES;

    if (!chunk_ok(WIDTH, STAGES)) begin : g_bad_cfg
        $error("pipe_adder: WIDTH must be a multiple of STAGES");
    end

    // Stage registers: index k holds the beat after chunk k has been added.
    // opa/opb carry the (already inverted for subtract) operands forward so
    // later chunks see them; acc holds the lower sum chunks completed so far.
    logic [STAGES-1:0] vld_q, vld_d;
    logic [STAGES-1:0] cy_q,  cy_d;
    logic [WIDTH-1:0]  opa_q [STAGES];
    logic [WIDTH-1:0]  opa_d [STAGES];
    logic [WIDTH-1:0]  opb_q [STAGES];
    logic [WIDTH-1:0]  opb_d [STAGES];
    logic [WIDTH-1:0]  acc_q [STAGES];
    logic [WIDTH-1:0]  acc_d [STAGES];

    // What each stage sees on its input side.
    logic [STAGES-1:0] st_vld;
    logic [STAGES-1:0] st_cy;
    logic [WIDTH-1:0]  st_opa [STAGES];
    logic [WIDTH-1:0]  st_opb [STAGES];
    logic [WIDTH-1:0]  st_acc [STAGES];

    logic [C-1:0]      ch_sum [STAGES];
    logic [STAGES-1:0] ch_cy;

    logic advance;

    assign advance      = !vld_q[STAGES-1] || bus.out_ready;
    assign bus.in_ready = advance;

    for (genvar k = 0; k < STAGES; k++) begin : g_stage
        if (k == 0) begin : g_head
            assign st_vld[k] = bus.in_valid;
            assign st_cy[k]  = bus.cin;
            assign st_opa[k] = bus.a;
            assign st_opb[k] = bus.sub ? ~bus.b : bus.b;
            assign st_acc[k] = '0;
        end else begin : g_body
            assign st_vld[k] = vld_q[k-1];
            assign st_cy[k]  = cy_q[k-1];
            assign st_opa[k] = opa_q[k-1];
            assign st_opb[k] = opb_q[k-1];
            assign st_acc[k] = acc_q[k-1];
        end

        add_chunk #(.C(C)) u_chunk (
            .a  (st_opa[k][k*C +: C]),
            .b  (st_opb[k][k*C +: C]),
            .ci (st_cy[k]),
            .s  (ch_sum[k]),
            .co (ch_cy[k])
        );
    end

    // Next-state: every stage shifts forward on advance, otherwise all hold.
    always_comb begin
        vld_d = vld_q;
        cy_d  = cy_q;
        opa_d = opa_q;
        opb_d = opb_q;
        acc_d = acc_q;
        if (advance) begin
            for (int k = 0; k < STAGES; k++) begin
                vld_d[k]            = st_vld[k];
                cy_d[k]             = ch_cy[k];
                opa_d[k]            = st_opa[k];
                opb_d[k]            = st_opb[k];
                acc_d[k]            = st_acc[k];
                acc_d[k][k*C +: C]  = ch_sum[k];
            end
        end
    end

    // Stage registers with synchronous reset; reset empties every stage.
    always_ff @(posedge clk) begin
        if (rst) begin
            vld_q <= '0;
            cy_q  <= '0;
            for (int k = 0; k < STAGES; k++) begin
                opa_q[k] <= '0;
                opb_q[k] <= '0;
                acc_q[k] <= '0;
            end
        end else begin
            vld_q <= vld_d;
            cy_q  <= cy_d;
            opa_q <= opa_d;
            opb_q <= opb_d;
            acc_q <= acc_d;
        end
    end

    assign bus.out_valid = vld_q[STAGES-1];
    assign bus.sum       = acc_q[STAGES-1];
    assign bus.cout      = cy_q[STAGES-1];

`ifdef PIPE_ADDER_FLAGS_EN
    flags_t flg_q, flg_d;

    // Flags are derived from the full sum as it enters the last register,
    // so they leave in the same cycle as the sum they describe.
    always_comb begin
        logic [WIDTH-1:0] res;
        logic             sa;
        logic             sb;
        flg_d = flg_q;
        res   = acc_d[STAGES-1];
        sa    = st_opa[STAGES-1][WIDTH-1];
        sb    = st_opb[STAGES-1][WIDTH-1];
        if (advance) begin
            flg_d.zero = (res == '0);
            flg_d.neg  = res[WIDTH-1];
            flg_d.ovf  = (sa == sb) && (res[WIDTH-1] != sa);
        end
    end

    // Flag register, cleared with the rest of the pipe.
    always_ff @(posedge clk) begin
        if (rst) begin
            flg_q <= '0;
        end else begin
            flg_q <= flg_d;
        end
    end

    assign bus.ovf  = flg_q.ovf;
    assign bus.zero = flg_q.zero;
    assign bus.neg  = flg_q.neg;
`endif

endmodule

// File: tb/tb_pipe_adder.sv
// Self-checking bench for pipe_adder (WIDTH=32, STAGES=4).
// Directed vector table plus stall, mid-flight reset and random traffic sequences.
// Flag checks are compiled in when PIPE_ADDER_FLAGS_EN is defined.
module tb_pipe_adder;
    import pipe_adder_pkg::*;

    localparam int W = 32;

    logic clk = 1'b0;
    logic rst;
    always #5 clk = ~clk;

    pipe_adder_if #(.WIDTH(W)) bus ();

    pipe_adder #(.WIDTH(W), .STAGES(4)) dut (
        .clk (clk),
        .rst (rst),
        .bus (bus)
    );

    int checks   = 0;
    int failures = 0;

    result_t exp_q[$];
    int      pushed = 0;
    int      popped = 0;
    bit      sb_en  = 1'b0;
    result_t mon_e;

    typedef struct {
        logic [31:0] a;
        logic [31:0] b;
        logic        cin;
        logic        sub;
        result_t     exp;
    } vec_t;

    vec_t vecs[11];

    function automatic vec_t mk(logic [31:0] a, logic [31:0] b, logic cin, logic sub,
                                logic [31:0] s, logic co, logic ovf, logic zero, logic neg);
        vec_t v;
        v.a = a; v.b = b; v.cin = cin; v.sub = sub;
        v.exp.sum = s; v.exp.cout = co;
        v.exp.flags.ovf = ovf; v.exp.flags.zero = zero; v.exp.flags.neg = neg;
        return v;
    endfunction

    // Golden model: full-width A + (sub ? ~B : B) + cin.
    function automatic result_t model(logic [31:0] a, logic [31:0] b, logic cin, logic sub);
        logic [31:0] be;
        logic [32:0] t;
        result_t     r;
        be = sub ? ~b : b;
        t  = {1'b0, a} + {1'b0, be} + {32'd0, cin};
        r.sum        = t[31:0];
        r.cout       = t[32];
        r.flags.zero = (t[31:0] == 32'd0);
        r.flags.neg  = t[31];
        r.flags.ovf  = (a[31] == be[31]) && (t[31] != a[31]);
        return r;
    endfunction

    task automatic chk(string name, logic [31:0] act, logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s: got %h expected %h", name, act, exp);
        end
    endtask

    task automatic chk_b(string name, logic act, logic exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s: got %b expected %b", name, act, exp);
        end
    endtask

    task automatic chk_res(string name, result_t e);
        chk({name, "_sum"}, bus.sum, e.sum);
        chk_b({name, "_cout"}, bus.cout, e.cout);
`ifdef PIPE_ADDER_FLAGS_EN
        chk_b({name, "_ovf"},  bus.ovf,  e.flags.ovf);
        chk_b({name, "_zero"}, bus.zero, e.flags.zero);
        chk_b({name, "_neg"},  bus.neg,  e.flags.neg);
`endif
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic set_beat(logic [31:0] a, logic [31:0] b, logic cin, logic sub);
        bus.a = a; bus.b = b; bus.cin = cin; bus.sub = sub;
    endtask

    // Scoreboard: handshakes sampled mid-cycle complete on the next rising edge.
    always @(negedge clk) begin
        if (sb_en) begin
            if (rst) begin
                exp_q.delete();
            end else begin
                if (bus.out_valid && bus.out_ready) begin
                    if (exp_q.size() == 0) begin
                        checks++;
                        failures++;
                        $display("FAIL sb_unexpected_beat: got sum %h with no beat outstanding", bus.sum);
                    end else begin
                        mon_e = exp_q.pop_front();
                        popped++;
                        chk_res($sformatf("sb_beat%0d", popped), mon_e);
                    end
                end
                if (bus.in_valid && bus.in_ready) begin
                    exp_q.push_back(model(bus.a, bus.b, bus.cin, bus.sub));
                    pushed++;
                end
            end
        end
    end

    initial begin
        int  i;
        bit  hold;
        int  cyc;
        int  sel;

        vecs[0]  = mk(32'hFFFFFFFF, 32'h00000001, 1'b0, 1'b0, 32'h00000000, 1'b1, 1'b0, 1'b1, 1'b0);
        vecs[1]  = mk(32'h00000005, 32'h00000007, 1'b1, 1'b1, 32'hFFFFFFFE, 1'b0, 1'b0, 1'b0, 1'b1);
        vecs[2]  = mk(32'h7FFFFFFF, 32'h00000001, 1'b0, 1'b0, 32'h80000000, 1'b0, 1'b1, 1'b0, 1'b1);
        vecs[3]  = mk(32'h00000000, 32'h00000000, 1'b0, 1'b0, 32'h00000000, 1'b0, 1'b0, 1'b1, 1'b0);
        vecs[4]  = mk(32'h12345678, 32'h11111111, 1'b0, 1'b0, 32'h23456789, 1'b0, 1'b0, 1'b0, 1'b0);
        vecs[5]  = mk(32'h0000FFFF, 32'h00000001, 1'b0, 1'b0, 32'h00010000, 1'b0, 1'b0, 1'b0, 1'b0);
        vecs[6]  = mk(32'h80000000, 32'h80000000, 1'b0, 1'b0, 32'h00000000, 1'b1, 1'b1, 1'b1, 1'b0);
        vecs[7]  = mk(32'h0000000A, 32'h00000003, 1'b1, 1'b1, 32'h00000007, 1'b1, 1'b0, 1'b0, 1'b0);
        vecs[8]  = mk(32'h80000000, 32'h00000001, 1'b1, 1'b1, 32'h7FFFFFFF, 1'b1, 1'b1, 1'b0, 1'b0);
        vecs[9]  = mk(32'h00FF00FF, 32'h00010001, 1'b1, 1'b0, 32'h01000101, 1'b0, 1'b0, 1'b0, 1'b0);
        vecs[10] = mk(32'h00000005, 32'h00000005, 1'b0, 1'b1, 32'hFFFFFFFF, 1'b0, 1'b0, 1'b0, 1'b1);

        // ---------------- reset ----------------
        rst = 1'b1;
        bus.in_valid = 1'b0; bus.out_ready = 1'b1;
        set_beat(32'd0, 32'd0, 1'b0, 1'b0);
        repeat (2) tick();
        chk_b("rst_out_valid", bus.out_valid, 1'b0);
        chk("rst_sum", bus.sum, 32'd0);
        chk_b("rst_cout", bus.cout, 1'b0);
`ifdef PIPE_ADDER_FLAGS_EN
        chk_b("rst_ovf", bus.ovf, 1'b0);
        chk_b("rst_zero", bus.zero, 1'b0);
        chk_b("rst_neg", bus.neg, 1'b0);
`endif
        rst = 1'b0;
        chk_b("rst_in_ready", bus.in_ready, 1'b1);

        // ---------------- directed table, one beat at a time ----------------
        for (int v = 0; v < 11; v++) begin
            set_beat(vecs[v].a, vecs[v].b, vecs[v].cin, vecs[v].sub);
            bus.in_valid = 1'b1;
            tick();
            bus.in_valid = 1'b0;
            if (v == 0) begin
                tick();
                tick();
                chk_b("latency_early_valid", bus.out_valid, 1'b0);
                tick();
            end else begin
                repeat (3) tick();
            end
            chk_b($sformatf("vec%0d_valid", v), bus.out_valid, 1'b1);
            chk_res($sformatf("vec%0d", v), vecs[v].exp);
        end
        tick();
        chk_b("table_drained", bus.out_valid, 1'b0);

        // ---------------- 8 back-to-back beats, consumer stalls cycles 5-7 ----------------
        exp_q.delete();
        pushed = 0; popped = 0; sb_en = 1'b1;
        i = 0;
        for (int c = 0; c < 20; c++) begin
            bus.in_valid  = (i < 8);
            set_beat(32'h0F0F0000 + 32'(i) * 32'h01010101, 32'(i) * 32'h11111111 + 32'hF0000000,
                     i[0], (i == 3) || (i == 6));
            bus.out_ready = !(c >= 5 && c <= 7);
            @(negedge clk);
            if (c <= 11)
                chk_b($sformatf("stall_in_ready_c%0d", c), bus.in_ready, !(c >= 5 && c <= 7));
            if (bus.in_valid && bus.in_ready) i++;
            tick();
        end
        bus.in_valid = 1'b0;
        chk("stall_accepted", pushed, 32'd8);
        chk("stall_delivered", popped, 32'd8);
        chk("stall_leftover", exp_q.size(), 32'd0);

        // ---------------- reset with four beats in flight ----------------
        sb_en = 1'b0;
        bus.out_ready = 1'b1;
        for (int j = 0; j < 4; j++) begin
            set_beat(32'hA0000000 + 32'(j), 32'h00000100, 1'b0, 1'b0);
            bus.in_valid = 1'b1;
            tick();
        end
        bus.in_valid = 1'b0;
        chk_b("inflight_out_valid", bus.out_valid, 1'b1);
        rst = 1'b1;
        tick();
        chk_b("midrst_out_valid", bus.out_valid, 1'b0);
        chk("midrst_sum", bus.sum, 32'd0);
        chk_b("midrst_cout", bus.cout, 1'b0);
        rst = 1'b0;
        chk_b("midrst_in_ready", bus.in_ready, 1'b1);
        for (int j = 0; j < 6; j++) begin
            tick();
            chk_b($sformatf("no_stale_c%0d", j), bus.out_valid, 1'b0);
        end
        set_beat(32'h00FFFFFF, 32'h00000001, 1'b0, 1'b0);
        bus.in_valid = 1'b1;
        tick();
        bus.in_valid = 1'b0;
        for (int j = 0; j < 3; j++) begin
            chk_b($sformatf("post_rst_wait%0d", j), bus.out_valid, 1'b0);
            tick();
        end
        chk_b("post_rst_valid", bus.out_valid, 1'b1);
        chk("post_rst_sum", bus.sum, 32'h01000000);
        chk_b("post_rst_cout", bus.cout, 1'b0);
        tick();

        // ---------------- random traffic ----------------
        exp_q.delete();
        pushed = 0; popped = 0; sb_en = 1'b1;
        hold = 1'b0;
        cyc  = 0;
        while (pushed < 10000 && cyc < 60000) begin
            if (!hold) begin
                bus.in_valid = ($urandom_range(0, 3) != 0);
                sel = $urandom_range(0, 7);
                bus.a   = $urandom;
                bus.b   = $urandom;
                bus.cin = $urandom_range(0, 1);
                bus.sub = $urandom_range(0, 1);
                if (sel == 0) bus.b = ~bus.a;
                if (sel == 1) bus.a = 32'hFFFFFFFF;
                if (sel == 2) bus.b = 32'h80000000;
            end
            bus.out_ready = ($urandom_range(0, 3) != 0);
            @(negedge clk);
            hold = bus.in_valid && !bus.in_ready;
            tick();
            cyc++;
        end
        bus.in_valid  = 1'b0;
        bus.out_ready = 1'b1;
        chk("rand_accepted", pushed, 32'd10000);
        for (int j = 0; j < 20 && exp_q.size() != 0; j++) tick();
        tick();
        chk("rand_delivered", popped, pushed);
        chk("rand_leftover", exp_q.size(), 32'd0);
        sb_en = 1'b0;

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
